// File: rtl/weird_rr_sched_if.sv
// weird_rr_sched_if
//   Bundles the scheduler's request, response and logic-unit signals.
//   slave  : scheduler side (accepts requests, drives the logic unit).
//   master : environment side (requesters, response consumer, logic unit).
//   Request  : req_valid/req_ready per requester, packed req_foo/req_bar/req_op.
//   Response : resp_valid/resp_ready, resp_data, resp_id.
//   Unit     : alu_en, alu_foo, alu_bar out; alu_and/or/xor/nand results in.
//   Status   : busy.
interface weird_rr_sched_if #(
  parameter int BITS = 4,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BITS-1:0] req_foo;
  logic [NREQ*BITS-1:0] req_bar;
  logic [NREQ*2-1:0]    req_op;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [BITS-1:0]      resp_data;
  logic [IDW-1:0]       resp_id;
  logic                 alu_en;
  logic [BITS-1:0]      alu_foo;
  logic [BITS-1:0]      alu_bar;
  logic [BITS-1:0]      alu_and;
  logic [BITS-1:0]      alu_or;
  logic [BITS-1:0]      alu_xor;
  logic [BITS-1:0]      alu_nand;
  logic                 busy;

  modport slave (
    input  req_valid, req_foo, req_bar, req_op, resp_ready,
    input  alu_and, alu_or, alu_xor, alu_nand,
    output req_ready, resp_valid, resp_data, resp_id,
    output alu_en, alu_foo, alu_bar, busy
  );

  modport master (
    output req_valid, req_foo, req_bar, req_op, resp_ready,
    output alu_and, alu_or, alu_xor, alu_nand,
    input  req_ready, resp_valid, resp_data, resp_id,
    input  alu_en, alu_foo, alu_bar, busy
  );
endinterface

// File: rtl/weird_rr_sched.sv
// weird_rr_sched
//   Round-robin scheduler sharing one registered bitwise logic unit among
//   NREQ requesters. One operation in flight at a time:
//   IDLE (grant) -> ISSUE (alu_en) -> WAIT (capture) -> RESP (handshake).
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : asynchronous active-high reset
//     bus  : weird_rr_sched_if.slave (request, response, logic-unit, busy)
module weird_rr_sched #(
  parameter int BITS = 4,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  weird_rr_sched_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [1:0]      op_q, op_d;
  logic [BITS-1:0] alu_foo_q, alu_foo_d;
  logic [BITS-1:0] alu_bar_q, alu_bar_d;
  logic            alu_en_q, alu_en_d;
  logic            resp_valid_q, resp_valid_d;
  logic [BITS-1:0] resp_data_q, resp_data_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic            busy_q, busy_d;

  logic            grant_found_s;
  logic [IDW-1:0]  grant_id_s;
  logic [IDW:0]    cand_s;
  logic [NREQ-1:0] req_ready_s;

  // Pick the logic-unit output matching the latched op code.
  function automatic logic [BITS-1:0] pick_result(
    input logic [1:0]      op,
    input logic [BITS-1:0] r_and,
    input logic [BITS-1:0] r_or,
    input logic [BITS-1:0] r_xor,
    input logic [BITS-1:0] r_nand
  );
    logic [BITS-1:0] r;
    case (op)
      2'd0:    r = r_and;
      2'd1:    r = r_or;
      2'd2:    r = r_xor;
      2'd3:    r = r_nand;
      default: r = r_and;
    endcase
    return r;
  endfunction

  // Round-robin search: first valid requester at rr_ptr, rr_ptr+1, ... wrapping at NREQ-1.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    cand_s        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      // Wrap explicitly so non-power-of-2 NREQ never yields an ID >= NREQ.
      if (cand_s >= (IDW+1)'(NREQ)) begin
        cand_s = cand_s - (IDW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && bus.req_valid[cand_s[IDW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_id_s    = cand_s[IDW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state and next-output logic for the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    op_d         = op_q;
    alu_foo_d    = alu_foo_q;
    alu_bar_d    = alu_bar_q;
    alu_en_d     = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    req_ready_s  = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          // Handshake completes this cycle; operands are latched now so later
          // changes by the requester cannot disturb the op.
          req_ready_s[grant_id_s] = 1'b1;
          alu_foo_d = bus.req_foo[grant_id_s*BITS +: BITS];
          alu_bar_d = bus.req_bar[grant_id_s*BITS +: BITS];
          op_d      = bus.req_op[grant_id_s*2 +: 2];
          id_d      = grant_id_s;
          alu_en_d  = 1'b1;      // registered: high during ISSUE only
          state_d   = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        resp_data_d  = pick_result(op_q, bus.alu_and, bus.alu_or, bus.alu_xor, bus.alu_nand);
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          // Pointer follows the granted ID, not the old pointer.
          rr_ptr_d = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      op_q         <= 2'd0;
      alu_foo_q    <= '0;
      alu_bar_q    <= '0;
      alu_en_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      op_q         <= op_d;
      alu_foo_q    <= alu_foo_d;
      alu_bar_q    <= alu_bar_d;
      alu_en_q     <= alu_en_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      busy_q       <= busy_d;
    end
  end

  // req_ready is the only combinational output; force it low while in reset.
  assign bus.req_ready  = rst ? '0 : req_ready_s;
  assign bus.alu_en     = alu_en_q;
  assign bus.alu_foo    = alu_foo_q;
  assign bus.alu_bar    = alu_bar_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_weird_rr_sched.sv
// tb_weird_rr_sched
//   Drives weird_rr_sched with directed and random requests, models the
//   shared logic unit, and checks every cycle against a transaction-level
//   reference: who should win, when each phase of an op is visible, and what
//   result the requester should get back.
module tb_weird_rr_sched;
  localparam int BITS = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int MASK = (1 << BITS) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weird_rr_sched_if #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW)) bus ();

  weird_rr_sched #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Shared logic unit: registered, 1-cycle latency, holds when alu_en is low.
  always @(posedge clk) begin
    if (bus.alu_en) begin
      bus.alu_and  <= bus.alu_foo & bus.alu_bar;
      bus.alu_or   <= bus.alu_foo | bus.alu_bar;
      bus.alu_xor  <= bus.alu_foo ^ bus.alu_bar;
      bus.alu_nand <= ~(bus.alu_foo & bus.alu_bar);
    end
  end

  function automatic int ref_result(input int a, input int b, input int op);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return (~(a & b)) & MASK;
    endcase
  endfunction

  // Reference model state (transaction level).
  int m_ptr = 0;
  bit m_pend = 1'b0;
  int m_id, m_res, m_acc;
  int m_foo = 0, m_bar = 0;
  int cyc = 0;
  int w, idx, c;
  int glog[$];   // granted IDs in order
  int gcyc[$];   // cycle of each grant
  int rdata[$];  // resp_data seen at each response handshake
  int rid[$];    // resp_id seen at each response handshake

  // Per-cycle reference check, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check_eq("rst_req_ready", bus.req_ready, 0);
      check_eq("rst_alu_en", bus.alu_en, 0);
      check_eq("rst_alu_foo", bus.alu_foo, 0);
      check_eq("rst_alu_bar", bus.alu_bar, 0);
      check_eq("rst_resp_valid", bus.resp_valid, 0);
      check_eq("rst_resp_data", bus.resp_data, 0);
      check_eq("rst_resp_id", bus.resp_id, 0);
      check_eq("rst_busy", bus.busy, 0);
      m_pend = 1'b0;
      m_ptr  = 0;
      m_foo  = 0;
      m_bar  = 0;
    end else begin
      check_eq("alu_foo_hold", bus.alu_foo, m_foo);
      check_eq("alu_bar_hold", bus.alu_bar, m_bar);
      if (!m_pend) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && bus.req_valid[idx]) w = idx;
        end
        check_eq("idle_busy", bus.busy, 0);
        check_eq("idle_alu_en", bus.alu_en, 0);
        check_eq("idle_resp_valid", bus.resp_valid, 0);
        check_eq("grant", bus.req_ready, (w < 0) ? 0 : (1 << w));
        if (w >= 0) begin
          m_pend = 1'b1;
          m_id   = w;
          m_foo  = int'(bus.req_foo[w*BITS +: BITS]);
          m_bar  = int'(bus.req_bar[w*BITS +: BITS]);
          m_res  = ref_result(m_foo, m_bar, int'(bus.req_op[w*2 +: 2]));
          m_acc  = cyc;
          glog.push_back(w);
          gcyc.push_back(cyc);
        end
      end else begin
        c = cyc - m_acc;
        check_eq("busy_ready", bus.req_ready, 0);
        check_eq("busy_flag", bus.busy, 1);
        check_eq("alu_en_pulse", bus.alu_en, (c == 1) ? 1 : 0);
        check_eq("resp_valid_time", bus.resp_valid, (c >= 3) ? 1 : 0);
        if (c >= 3) begin
          check_eq("resp_data", bus.resp_data, m_res);
          check_eq("resp_id", bus.resp_id, m_id);
          if (bus.resp_ready) begin
            rdata.push_back(int'(bus.resp_data));
            rid.push_back(int'(bus.resp_id));
            m_ptr  = (m_id + 1) % NREQ;
            m_pend = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int id, input int foo, input int bar, input int op);
    bus.req_foo[id*BITS +: BITS] = BITS'(foo);
    bus.req_bar[id*BITS +: BITS] = BITS'(bar);
    bus.req_op[id*2 +: 2]        = 2'(op);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (glog.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq("grant_wait", (glog.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_resps(input int n, input int budget);
    int k = 0;
    while (rdata.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq("resp_wait", (rdata.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_pend || bus.busy) && k < budget) begin
      tick();
      k++;
    end
    check_eq("idle_wait", (m_pend || bus.busy) ? 1 : 0, 0);
  endtask

  // One complete op from a single requester, result checked against a constant.
  task automatic do_op(input int id, input int foo, input int bar, input int op, input int exp);
    int g0 = glog.size();
    int r0 = rdata.size();
    set_slot(id, foo, bar, op);
    bus.resp_ready = 1'b1;
    bus.req_valid  = NREQ'(1 << id);
    wait_grants(g0 + 1, 20);
    bus.req_valid = '0;
    set_slot(id, ~foo, ~bar, op ^ 1);   // post-accept changes must not matter
    wait_resps(r0 + 1, 20);
    check_eq("op_data", (rdata.size() > r0) ? rdata[r0] : -1, exp);
    check_eq("op_id", (rid.size() > r0) ? rid[r0] : -1, id);
  endtask

  initial begin
    int k;
    int g0, r0;
    int exp_fair[5] = '{0, 1, 2, 3, 0};
    int exp_wrap[4] = '{2, 3, 1, 1};
    int exp_rst[2]  = '{3, 0};

    bus.req_valid  = '0;
    bus.req_foo    = '0;
    bus.req_bar    = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single op and every op code.
    do_op(0, 'hC, 'hA, 0, 'h8);
    do_op(0, 'h3, 'h5, 1, 'h7);
    do_op(0, 'h3, 'h5, 2, 'h6);
    do_op(0, 'h3, 'h5, 3, 'hE);
    do_op(0, 'hF, 'h0, 2, 'hF);
    do_op(3, 'h9, 'h6, 0, 'h0);   // leaves the pointer at 0

    // Fairness with all requesters active.
    wait_idle(20);
    glog.delete();
    gcyc.delete();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'hF;
    wait_grants(5, 40);
    bus.req_valid = '0;
    wait_idle(20);
    for (int i = 0; i < 5; i++) begin
      check_eq("fair_order", (glog.size() > i) ? glog[i] : -1, exp_fair[i]);
      if (i > 0) check_eq("fair_gap", (gcyc.size() > i) ? gcyc[i] - gcyc[i-1] : -1, 4);
    end

    // Wrap and skip.
    glog.delete();
    bus.req_valid = 4'b0100;
    wait_grants(1, 20);
    bus.req_valid = 4'b1010;
    wait_grants(3, 30);
    bus.req_valid = 4'b0010;
    wait_grants(4, 20);
    bus.req_valid = '0;
    wait_idle(20);
    for (int i = 0; i < 4; i++) begin
      check_eq("wrap_order", (glog.size() > i) ? glog[i] : -1, exp_wrap[i]);
    end

    // Backpressure: response held for 5 cycles while others are waiting.
    glog.delete();
    bus.resp_ready = 1'b0;
    set_slot(1, 'h6, 'hB, 2);
    bus.req_valid = 4'b0010;
    wait_grants(1, 20);
    bus.req_valid = 4'hF;
    k = 0;
    while (!bus.resp_valid && k < 10) begin
      tick();
      k++;
    end
    check_eq("bp_resp_seen", bus.resp_valid, 1);
    repeat (5) tick();
    check_eq("bp_still_valid", bus.resp_valid, 1);
    check_eq("bp_data", bus.resp_data, 'hD);
    bus.resp_ready = 1'b1;
    wait_grants(2, 20);
    bus.req_valid = '0;
    wait_idle(20);
    check_eq("bp_next_grant", (glog.size() > 1) ? glog[1] : -1, 2);

    // Reset during ISSUE: op is dropped, pointer back to 0.
    set_slot(2, 'h5, 'h5, 1);
    bus.req_valid = 4'b0100;
    k = 0;
    while (!bus.alu_en && k < 20) begin
      tick();
      k++;
    end
    check_eq("midop_issue_seen", bus.alu_en, 1);
    r0 = rdata.size();
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    check_eq("rst_async_alu_en", bus.alu_en, 0);
    check_eq("rst_async_busy", bus.busy, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    check_eq("midop_no_resp", rdata.size(), r0);
    glog.delete();
    bus.req_valid = 4'b1000;
    wait_grants(1, 20);
    bus.req_valid = '0;
    wait_idle(20);
    bus.req_valid = 4'hF;
    wait_grants(2, 20);
    bus.req_valid = '0;
    wait_idle(20);
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_order", (glog.size() > i) ? glog[i] : -1, exp_rst[i]);
    end

    // Random traffic with random backpressure; the model checks every cycle.
    g0 = 0;
    repeat (400) begin
      bus.req_valid  = ($urandom_range(0, 4) == 0) ? '0 : NREQ'($urandom_range(0, 15));
      bus.req_foo    = (NREQ*BITS)'($urandom);
      bus.req_bar    = (NREQ*BITS)'($urandom);
      bus.req_op     = (NREQ*2)'($urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      tick();
      g0++;
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    wait_idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
